// File: rtl/usb_cmd_frame_parser.sv
// ============================================================================
// Module      : usb_cmd_frame_parser
// Description : USB byte-stream deframer (AA 55 CMD LEN_H LEN_L PAYLOAD CHK).
//               Optional inter-byte timeout enabled by macro CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_cmd_frame_parser #(
    parameter int MAX_PAYLOAD_LEN = 128
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 50000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic        cmd_start,
    output logic [7:0]  cmd_data,
    output logic [15:0] cmd_data_index,
    output logic        cmd_data_valid,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [1:0]  cmd_err_code
);

    localparam logic [15:0] MAX_LEN16   = 16'(MAX_PAYLOAD_LEN);
    localparam logic [1:0]  ERR_CHKSUM  = 2'd1;
    localparam logic [1:0]  ERR_LENGTH  = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_SYNC0 = 3'd0,
        S_SYNC1 = 3'd1,
        S_CMD   = 3'd2,
        S_LENH  = 3'd3,
        S_LENL  = 3'd4,
        S_DATA  = 3'd5,
        S_CHK   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  pend_type_q, pend_type_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [15:0] idx_q, idx_d;

    logic [7:0]  cmd_type_q, cmd_type_d;
    logic [15:0] cmd_length_q, cmd_length_d;
    logic        cmd_start_q, cmd_start_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic [15:0] cmd_index_q, cmd_index_d;
    logic        cmd_dvalid_q, cmd_dvalid_d;
    logic        cmd_done_q, cmd_done_d;
    logic        cmd_error_q, cmd_error_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [15:0] rx_len;
    logic        timeout_hit;

    assign rx_len = {len_hi_q, usb_data_in};

`ifdef CMD_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle clocks are counted only while a frame is in progress.
    always_comb begin
        tmo_d       = '0;
        timeout_hit = 1'b0;
        if (!usb_data_valid_in && (state_q != S_SYNC0)) begin
            if (tmo_q == TMO_LAST) begin
                timeout_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        pend_type_d  = pend_type_q;
        len_hi_d     = len_hi_q;
        frame_len_d  = frame_len_q;
        idx_d        = idx_q;
        cmd_type_d   = cmd_type_q;
        cmd_length_d = cmd_length_q;
        cmd_data_d   = cmd_data_q;
        cmd_index_d  = cmd_index_q;
        err_code_d   = err_code_q;
        cmd_start_d  = 1'b0;
        cmd_dvalid_d = 1'b0;
        cmd_done_d   = 1'b0;
        cmd_error_d  = 1'b0;

        if (usb_data_valid_in) begin
            case (state_q)
                S_SYNC0: begin
                    if (usb_data_in == 8'hAA) state_d = S_SYNC1;
                end
                S_SYNC1: begin
                    if (usb_data_in == 8'h55) begin
                        state_d = S_CMD;
                    end else if (usb_data_in != 8'hAA) begin
                        state_d = S_SYNC0;
                    end
                end
                S_CMD: begin
                    pend_type_d = usb_data_in;
                    sum_d       = usb_data_in;
                    state_d     = S_LENH;
                end
                S_LENH: begin
                    len_hi_d = usb_data_in;
                    sum_d    = sum_q + usb_data_in;
                    state_d  = S_LENL;
                end
                S_LENL: begin
                    sum_d = sum_q + usb_data_in;
                    if (rx_len > MAX_LEN16) begin
                        cmd_error_d = 1'b1;
                        err_code_d  = ERR_LENGTH;
                        state_d     = S_SYNC0;
                    end else begin
                        // Header is published together with the start pulse.
                        cmd_start_d  = 1'b1;
                        cmd_type_d   = pend_type_q;
                        cmd_length_d = rx_len;
                        frame_len_d  = rx_len;
                        idx_d        = '0;
                        state_d      = (rx_len == 16'd0) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    cmd_dvalid_d = 1'b1;
                    cmd_data_d   = usb_data_in;
                    cmd_index_d  = idx_q;
                    sum_d        = sum_q + usb_data_in;
                    idx_d        = idx_q + 16'd1;
                    if (idx_q == frame_len_q - 16'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (usb_data_in == sum_q) begin
                        cmd_done_d = 1'b1;
                    end else begin
                        cmd_error_d = 1'b1;
                        err_code_d  = ERR_CHKSUM;
                    end
                    state_d = S_SYNC0;
                end
                default: state_d = S_SYNC0;
            endcase
        end else if (timeout_hit) begin
            cmd_error_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_SYNC0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SYNC0;
            sum_q        <= '0;
            pend_type_q  <= '0;
            len_hi_q     <= '0;
            frame_len_q  <= '0;
            idx_q        <= '0;
            cmd_type_q   <= '0;
            cmd_length_q <= '0;
            cmd_start_q  <= 1'b0;
            cmd_data_q   <= '0;
            cmd_index_q  <= '0;
            cmd_dvalid_q <= 1'b0;
            cmd_done_q   <= 1'b0;
            cmd_error_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            pend_type_q  <= pend_type_d;
            len_hi_q     <= len_hi_d;
            frame_len_q  <= frame_len_d;
            idx_q        <= idx_d;
            cmd_type_q   <= cmd_type_d;
            cmd_length_q <= cmd_length_d;
            cmd_start_q  <= cmd_start_d;
            cmd_data_q   <= cmd_data_d;
            cmd_index_q  <= cmd_index_d;
            cmd_dvalid_q <= cmd_dvalid_d;
            cmd_done_q   <= cmd_done_d;
            cmd_error_q  <= cmd_error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign cmd_type       = cmd_type_q;
    assign cmd_length     = cmd_length_q;
    assign cmd_start      = cmd_start_q;
    assign cmd_data       = cmd_data_q;
    assign cmd_data_index = cmd_index_q;
    assign cmd_data_valid = cmd_dvalid_q;
    assign cmd_done       = cmd_done_q;
    assign cmd_error      = cmd_error_q;
    assign cmd_err_code   = err_code_q;

endmodule

`default_nettype wire
